if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined core.
- Owns the PC register; `if_pc_o` drives the next-PC unit's PC input, and `npc_i` returns the next-PC result.
- Issues one-outstanding-request fetches to instruction memory over a req/gnt/rvalid handshake.
- Loads the IF/ID pipeline register. Handles hazard-unit stalls and EX-stage redirects (branch, jal, jalr).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word presented when the IF/ID register holds a bubble (addi x0,x0,0).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- npc_i  in  32  next PC from the next-PC unit (PC+4 or redirect target).
- redirect_i  in  1  EX-stage taken branch/jump: flush and load npc_i.
- stall_i  in  1  hazard unit: hold IF/ID and the PC.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address; always equal to pc_q.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response valid; at most one per granted request, never in the grant cycle.
- imem_rdata_i  in  32  instruction word.
- if_pc_o  out  32  current PC register (pc_q).
- id_valid_o  out  1  IF/ID holds a live instruction.
- id_pc_o  out  32  PC of the IF/ID instruction.
- id_instr_o  out  32  IF/ID instruction word.

Behaviour:
- Reset (async, active-high) values:
  - pc_q=RESET_PC, state=IDLE, imem_req_o=0, kill=0, buf_valid=0.
  - id_valid_o=0, id_pc_o=0, id_instr_o=NOP_INSTR.
- States and transitions:
  - IDLE: one cycle after reset release, then REQ.
  - REQ: imem_req_o=1. On gnt go to WAIT. Address may change only via redirect.
  - WAIT: imem_req_o=0. Waits for rvalid.
  - HOLD: response captured in a one-entry buffer while stall_i=1.
- rvalid in WAIT:
  - kill=1: discard the word, clear kill, go to REQ.
  - stall_i=0: IF/ID <= {1, pc_q, rdata}, pc_q <= npc_i, go to REQ.
  - stall_i=1: buffer <= {pc_q, rdata}, go to HOLD.
- HOLD with stall_i=0: IF/ID <= buffer, pc_q <= npc_i, go to REQ.
- IF/ID bubbles: if stall_i=0 and no instruction is delivered in a cycle, IF/ID <= bubble (valid=0, instr=NOP_INSTR, pc=0). If stall_i=1, IF/ID holds.
- Redirect (priority over stall and over delivery):
  - pc_q <= npc_i; IF/ID <= bubble; buffer dropped.
  - In WAIT, or in REQ with gnt the same cycle: set kill.
  - In HOLD: go to REQ.
  - In REQ without gnt: stay in REQ; the new address appears next cycle.
- Timing:
  - Best-case latency: gnt in cycle N, rvalid in N+1, IF/ID valid from N+2.
  - Throughput: 1 instruction per 2 cycles.
- Width rules: all PC arithmetic is external. PC is 32 bits and wraps modulo 2^32, with no check.
- Boundary conditions:
  - Redirect and rvalid in the same cycle: the word is discarded and kill is not left set.
  - Back-to-back redirects: the last target wins; kill stays a single bit, since only one request is ever outstanding.
  - Reset mid-transaction: a pending rvalid after reset release is ignored, because state is not WAIT.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined, add outputs perf_fetch_o[31:0] and perf_kill_o[31:0]. Both reset to 0 and wrap.
  - perf_fetch_o increments on each instruction loaded into IF/ID.
  - perf_kill_o increments on each discarded response.
- When undefined, these ports and counters do not exist and the stage behaves identically otherwise.

Decomposition:
- Shared package if_pkg holds:
  - the state encoding (IDLE, REQ, WAIT, HOLD);
  - the NOP_INSTR constant;
  - the default RESET_PC.
- Sub-module if_id_reg: IF/ID register with load/hold/bubble controls (flush wins over hold), reused by the integrator.

Test Plan:
- Reset release, memory grants immediately and rvalid the next cycle, npc_i=pc+4 → imem_addr_o sequence 0x0, 0x4, 0x8; IF/ID valid with id_pc_o 0x0, 0x4 every 2 cycles.
- stall_i=1 for 3 cycles while rvalid arrives for 0x8 → IF/ID holds 0x4; on release, IF/ID=0x8 with the correct word and pc_q advances to 0xC.
- redirect_i=1 with npc_i=0x100 while in WAIT → id_valid_o=0 next cycle; the returning word is dropped; next request address is 0x100.
- redirect_i and imem_gnt_i in the same cycle in REQ → the response is discarded (perf_kill_o=1 if enabled); the following fetch is at the target.
- gnt held low for 4 cycles → imem_req_o stays 1 with stable imem_addr_o; id_valid_o=0 throughout.
- rst asserted in WAIT, then a stray rvalid after release → ignored; first fetch is at RESET_PC and id_instr_o=0x00000013 until the first delivery.

Source files
------------

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// reset/bubble constants and the fetched-instruction payload.
package if_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] IF_RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] IF_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } if_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_t;

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load, and with none
// of them asserted the register takes a bubble.
module if_id_reg
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            hold,
    input  logic            flush,
    input  fetch_t          din,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr
);

    // Register update with flush > hold > load > bubble priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP_INSTR;
        end else if (flush) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP_INSTR;
        end else if (hold) begin
            valid <= valid;
            pc    <= pc;
            instr <= instr;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= din.pc;
            instr <= din.instr;
        end else begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP_INSTR;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding
// req/gnt/rvalid fetch to instruction memory and fills the IF/ID register.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = if_pkg::IF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = if_pkg::IF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc_i,
    input  logic        redirect_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_pc_o,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_instr_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_kill_o
`endif
);

    import if_pkg::*;

    if_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic            buf_valid_q, buf_valid_d;
    fetch_t          buf_q, buf_d;
    logic            req_q;
    logic            id_load;
    logic            id_flush;
    fetch_t          id_din;

    // State, PC, kill flag, response buffer and registered request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            kill_q      <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_q       <= '0;
            req_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            buf_valid_q <= buf_valid_d;
            buf_q       <= buf_d;
            req_q       <= (state_d == ST_REQ);
        end
    end

    // Next-state, PC update and IF/ID control; redirect overrides everything
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        buf_valid_d = buf_valid_q;
        buf_d       = buf_q;
        id_load     = 1'b0;
        id_flush    = 1'b0;
        id_din      = '{pc: pc_q, instr: imem_rdata_i};

        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (imem_gnt_i) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
                    end else if (!stall_i) begin
                        id_load = 1'b1;
                        pc_d    = npc_i;
                        state_d = ST_REQ;
                    end else begin
                        buf_d       = '{pc: pc_q, instr: imem_rdata_i};
                        buf_valid_d = 1'b1;
                        state_d     = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!stall_i && buf_valid_q) begin
                    id_load     = 1'b1;
                    id_din      = buf_q;
                    pc_d        = npc_i;
                    buf_valid_d = 1'b0;
                    state_d     = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (redirect_i) begin
            pc_d        = npc_i;
            id_load     = 1'b0;
            id_flush    = 1'b1;
            buf_valid_d = 1'b0;
            case (state_q)
                ST_WAIT: begin
                    // A response landing with the redirect is dropped outright,
                    // so no kill is left behind for it.
                    if (imem_rvalid_i) begin
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        kill_d  = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
                ST_REQ: begin
                    if (imem_gnt_i) begin
                        kill_d  = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_HOLD: state_d = ST_REQ;
                default: state_d = ST_REQ;
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (id_load),
        .hold  (stall_i),
        .flush (id_flush),
        .din   (id_din),
        .valid (id_valid_o),
        .pc    (id_pc_o),
        .instr (id_instr_o)
    );

    assign imem_req_o  = req_q;
    assign imem_addr_o = pc_q;
    assign if_pc_o     = pc_q;

`ifdef IF_PERF_CNT_EN
    logic discard;

    // A response is discarded when killed, hit by a redirect, or dropped from the buffer
    always_comb begin
        discard = 1'b0;
        if (state_q == ST_WAIT && imem_rvalid_i && (kill_q || redirect_i)) discard = 1'b1;
        if (state_q == ST_HOLD && redirect_i && buf_valid_q)               discard = 1'b1;
    end

    // Free-running, wrapping event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_o <= '0;
            perf_kill_o  <= '0;
        end else begin
            if (id_load) perf_fetch_o <= perf_fetch_o + 32'd1;
            if (discard) perf_kill_o  <= perf_kill_o + 32'd1;
        end
    end
`else
    // Counters not built in this configuration.
`endif

endmodule
